// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses the instruction memory,
// captures {instruction, PC} into the IF/ID register under a valid/ready
// handshake, applies branch/jump redirects from decode, and halts with a
// sticky fault when the PC walks past the populated instruction range.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 32,
    parameter int          CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_inst,
    output logic             id_valid,
    input  logic             id_ready,
    output logic [31:0]      id_inst,
    output logic [31:0]      id_pc,
    input  logic             jump,
    input  logic [25:0]      jump_index,
    input  logic             br_taken,
    input  logic [15:0]      br_offset,
    output logic             fetch_fault,
    output logic [CNT_W-1:0] fetch_count
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    // One past the last legal byte address; 33 bits so the compare cannot wrap.
    localparam logic [32:0]      PC_LIMIT = 33'(IMEM_WORDS) << 2;
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_t      state;
    logic [31:0] pc;

    logic        accept;
    logic        load;
    logic        redirect;
    logic        pc_out_of_range;
    logic [31:0] id_seq_pc;
    logic [31:0] jump_target;
    logic [31:0] br_target;
    logic [31:0] redirect_target;

    assign imem_addr = pc;

    assign accept          = id_valid & id_ready;
    assign load            = (state == RUN) & (~id_valid | id_ready);
    // jump/br_taken describe the instruction in IF/ID, so they only count when decode takes it.
    assign redirect        = accept & (jump | br_taken);
    assign pc_out_of_range = ({1'b0, pc} >= PC_LIMIT);

    // Targets are relative to the instruction being accepted, not the fetch PC.
    assign id_seq_pc       = id_pc + 32'd4;
    assign jump_target     = {id_seq_pc[31:28], jump_index, 2'b00};
    assign br_target       = id_seq_pc + {{14{br_offset[15]}}, br_offset, 2'b00};
    assign redirect_target = jump ? jump_target : br_target;

    // Fetch FSM: PC update, IF/ID capture, fault latching and accept counting.
    // NOTE: every register here is state, so all updates use <=; the priority
    // chain below reads the pre-edge values of pc/id_valid/state consistently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            pc          <= RESET_PC;
            id_valid    <= 1'b0;
            id_inst     <= 32'h0;
            id_pc       <= 32'h0;
            fetch_fault <= 1'b0;
            fetch_count <= '0;
        end else begin
            if (accept && (fetch_count != CNT_MAX)) begin
                fetch_count <= fetch_count + CNT_W'(1);
            end

            case (state)
                RUN: begin
                    if (redirect) begin
                        // The word fetched this cycle is wrong-path: drop it.
                        pc       <= redirect_target;
                        id_valid <= 1'b0;
                    end else if (load && pc_out_of_range) begin
                        // PC is left pointing at the offending address.
                        id_valid    <= 1'b0;
                        fetch_fault <= 1'b1;
                        state       <= HALT;
                    end else if (load) begin
                        id_inst  <= imem_inst;
                        id_pc    <= pc;
                        id_valid <= 1'b1;
                        pc       <= pc + 32'd4;
                    end
                end
                HALT: begin
                    if (accept) begin
                        id_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit. The bench plays the decode stage and
// the instruction memory; a transaction-level model tracks which instruction
// decode should be looking at, where fetch goes next, and the accept count.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_inst;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic        jump;
    logic [25:0] jump_index;
    logic        br_taken;
    logic [15:0] br_offset;
    logic        fetch_fault;
    logic [15:0] fetch_count;

    // Second instance with a narrow counter, always ready, no redirects.
    logic [31:0] s_imem_addr;
    logic [31:0] s_imem_inst;
    logic        s_id_valid;
    logic [31:0] s_id_inst;
    logic [31:0] s_id_pc;
    logic        s_fetch_fault;
    logic [3:0]  s_fetch_count;

    logic [31:0] mem [0:31];

    int compared   = 0;
    int mismatched = 0;

    // Model: instruction decode should see, next fetch address, fault, accepts.
    bit          m_valid;
    bit          m_fault;
    logic [31:0] m_pc;
    logic [31:0] m_next;
    int          m_count;

    always #5 clk = ~clk;

    assign imem_inst   = (imem_addr   < 32'd128) ? mem[imem_addr[6:2]]   : 32'hDEAD_BEEF;
    assign s_imem_inst = (s_imem_addr < 32'd128) ? mem[s_imem_addr[6:2]] : 32'hDEAD_BEEF;

    fetch_unit #(.RESET_PC(32'h0), .IMEM_WORDS(32), .CNT_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_addr   (imem_addr),
        .imem_inst   (imem_inst),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_inst     (id_inst),
        .id_pc       (id_pc),
        .jump        (jump),
        .jump_index  (jump_index),
        .br_taken    (br_taken),
        .br_offset   (br_offset),
        .fetch_fault (fetch_fault),
        .fetch_count (fetch_count)
    );

    fetch_unit #(.RESET_PC(32'h0), .IMEM_WORDS(32), .CNT_W(4)) dut_sat (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_addr   (s_imem_addr),
        .imem_inst   (s_imem_inst),
        .id_valid    (s_id_valid),
        .id_ready    (1'b1),
        .id_inst     (s_id_inst),
        .id_pc       (s_id_pc),
        .jump        (1'b0),
        .jump_index  (26'd0),
        .br_taken    (1'b0),
        .br_offset   (16'd0),
        .fetch_fault (s_fetch_fault),
        .fetch_count (s_fetch_count)
    );

    task automatic model_reset();
        m_valid = 1'b0;
        m_fault = 1'b0;
        m_pc    = 32'h0;
        m_next  = 32'h0;
        m_count = 0;
    endtask

    // Drive decode-side inputs for one clock and advance the model by one edge.
    // Returns on the following falling edge, where outputs are sampled.
    task automatic tick(input bit r, input bit j, input bit b,
                        input logic [25:0] ji, input logic [15:0] bo);
        int o;
        id_ready   = r;
        jump       = j;
        br_taken   = b;
        jump_index = ji;
        br_offset  = bo;
        @(posedge clk);
        if (m_valid && r) m_count = (m_count < 65535) ? m_count + 1 : 65535;
        if (m_fault) begin
            if (m_valid && r) m_valid = 1'b0;
        end else if (!m_valid || r) begin
            if (m_valid && (j || b)) begin
                o = $signed(bo);
                if (j) m_next = ((m_pc + 32'd4) & 32'hF000_0000) | ({6'd0, ji} << 2);
                else   m_next = m_pc + 32'd4 + 32'(o * 4);
                m_valid = 1'b0;
            end else if (m_next >= 32'd128) begin
                m_fault = 1'b1;
                m_valid = 1'b0;
            end else begin
                m_valid = 1'b1;
                m_pc    = m_next;
                m_next  = m_next + 32'd4;
            end
        end
        @(negedge clk);
    endtask

    // Pulse reset from a falling edge; released before the next rising edge.
    task automatic do_reset();
        id_ready   = 1'b0;
        jump       = 1'b0;
        br_taken   = 1'b0;
        jump_index = 26'd0;
        br_offset  = 16'd0;
        rst_n      = 1'b0;
        model_reset();
        #3;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        id_ready   = 1'b0;
        jump       = 1'b0;
        br_taken   = 1'b0;
        jump_index = 26'd0;
        br_offset  = 16'd0;
        model_reset();
        #12;
        compared++; if (id_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %0b want 0", id_valid); end
        compared++; if (id_inst !== 32'h0) begin mismatched++; $display("FAIL reset_inst: got %h want 0", id_inst); end
        compared++; if (id_pc !== 32'h0) begin mismatched++; $display("FAIL reset_id_pc: got %h want 0", id_pc); end
        compared++; if (imem_addr !== 32'h0) begin mismatched++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
        compared++; if (fetch_fault !== 1'b0) begin mismatched++; $display("FAIL reset_fault: got %0b want 0", fetch_fault); end
        compared++; if (fetch_count !== 16'h0) begin mismatched++; $display("FAIL reset_count: got %0d want 0", fetch_count); end
        rst_n = 1'b1;
    endtask

    task automatic test_sequential();
        tick(1'b1, 1'b0, 1'b0, 26'd0, 16'd0);
        compared++; if (id_valid !== 1'b1) begin mismatched++; $display("FAIL seq0_valid: got %0b want 1", id_valid); end
        compared++; if (id_inst !== 32'h2001_0008) begin mismatched++; $display("FAIL seq0_inst: got %h want 20010008", id_inst); end
        compared++; if (id_pc !== 32'h0) begin mismatched++; $display("FAIL seq0_pc: got %h want 0", id_pc); end
        compared++; if (fetch_count !== 16'd0) begin mismatched++; $display("FAIL seq0_count: got %0d want 0", fetch_count); end
        tick(1'b1, 1'b0, 1'b0, 26'd0, 16'd0);
        compared++; if (id_inst !== 32'h3402_000C) begin mismatched++; $display("FAIL seq1_inst: got %h want 3402000c", id_inst); end
        compared++; if (id_pc !== 32'h4) begin mismatched++; $display("FAIL seq1_pc: got %h want 4", id_pc); end
        compared++; if (fetch_count !== 16'd1) begin mismatched++; $display("FAIL seq1_count: got %0d want 1", fetch_count); end
        tick(1'b1, 1'b0, 1'b0, 26'd0, 16'd0);
        compared++; if (id_pc !== 32'h8) begin mismatched++; $display("FAIL seq2_pc: got %h want 8", id_pc); end
        compared++; if (fetch_count !== 16'd2) begin mismatched++; $display("FAIL seq2_count: got %0d want 2", fetch_count); end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0, 1'b0, 26'd0, 16'd0);
            compared++; if (id_valid !== 1'b1) begin mismatched++; $display("FAIL stall%0d_valid: got %0b want 1", i, id_valid); end
            compared++; if (id_pc !== 32'h8) begin mismatched++; $display("FAIL stall%0d_pc: got %h want 8", i, id_pc); end
            compared++; if (id_inst !== mem[2]) begin mismatched++; $display("FAIL stall%0d_inst: got %h want %h", i, id_inst, mem[2]); end
            compared++; if (imem_addr !== 32'hC) begin mismatched++; $display("FAIL stall%0d_addr: got %h want c", i, imem_addr); end
        end
        tick(1'b1, 1'b0, 1'b0, 26'd0, 16'd0);
        compared++; if (id_pc !== 32'hC) begin mismatched++; $display("FAIL stall_release_pc: got %h want c", id_pc); end
        compared++; if (fetch_count !== 16'd3) begin mismatched++; $display("FAIL stall_count: got %0d want 3", fetch_count); end
    endtask

    task automatic advance_to(input logic [31:0] target, input string tag);
        int n = 0;
        while (id_pc !== target && n < 40) begin
            tick(1'b1, 1'b0, 1'b0, 26'd0, 16'd0);
            n++;
        end
        compared++; if (id_pc !== target) begin mismatched++; $display("FAIL %s_reach: got %h want %h", tag, id_pc, target); end
    endtask

    task automatic test_branch();
        advance_to(32'h18, "branch");
        tick(1'b1, 1'b0, 1'b1, 26'd0, 16'h0002);
        compared++; if (id_valid !== 1'b0) begin mismatched++; $display("FAIL br_bubble: got %0b want 0", id_valid); end
        compared++; if (imem_addr !== 32'h24) begin mismatched++; $display("FAIL br_fwd_addr: got %h want 24", imem_addr); end
        tick(1'b1, 1'b0, 1'b0, 26'd0, 16'd0);
        compared++; if (id_pc !== 32'h24) begin mismatched++; $display("FAIL br_fwd_pc: got %h want 24", id_pc); end
        compared++; if (id_valid !== 1'b1) begin mismatched++; $display("FAIL br_fwd_valid: got %0b want 1", id_valid); end
        tick(1'b1, 1'b0, 1'b1, 26'd0, 16'hFFFC);
        tick(1'b1, 1'b0, 1'b0, 26'd0, 16'd0);
        compared++; if (id_pc !== 32'h18) begin mismatched++; $display("FAIL br_back_pc: got %h want 18", id_pc); end
        tick(1'b1, 1'b0, 1'b1, 26'd0, 16'hFFFE);
        compared++; if (imem_addr !== 32'h14) begin mismatched++; $display("FAIL br_neg_addr: got %h want 14", imem_addr); end
        tick(1'b1, 1'b0, 1'b0, 26'd0, 16'd0);
        compared++; if (id_pc !== 32'h14) begin mismatched++; $display("FAIL br_neg_pc: got %h want 14", id_pc); end
    endtask

    task automatic test_jump();
        advance_to(32'h28, "jump");
        tick(1'b0, 1'b1, 1'b0, 26'h0D, 16'd0);
        compared++; if (id_valid !== 1'b1 || id_pc !== 32'h28) begin mismatched++; $display("FAIL jmp_stall_ignored: got valid=%0b pc=%h want 1/28", id_valid, id_pc); end
        compared++; if (imem_addr !== 32'h2C) begin mismatched++; $display("FAIL jmp_stall_addr: got %h want 2c", imem_addr); end
        tick(1'b1, 1'b1, 1'b1, 26'h0D, 16'h0040);
        compared++; if (id_valid !== 1'b0) begin mismatched++; $display("FAIL jmp_bubble: got %0b want 0", id_valid); end
        compared++; if (imem_addr !== 32'h34) begin mismatched++; $display("FAIL jmp_addr: got %h want 34", imem_addr); end
        tick(1'b1, 1'b0, 1'b0, 26'd0, 16'd0);
        compared++; if (id_pc !== 32'h34) begin mismatched++; $display("FAIL jmp_pc: got %h want 34", id_pc); end
    endtask

    task automatic test_fault();
        int n = 0;
        while (fetch_fault !== 1'b1 && n < 64) begin
            tick(1'b1, 1'b0, 1'b0, 26'd0, 16'd0);
            n++;
        end
        compared++; if (fetch_fault !== 1'b1) begin mismatched++; $display("FAIL fault_flag: got %0b want 1", fetch_fault); end
        compared++; if (id_valid !== 1'b0) begin mismatched++; $display("FAIL fault_valid: got %0b want 0", id_valid); end
        compared++; if (imem_addr !== 32'h80) begin mismatched++; $display("FAIL fault_addr: got %h want 80", imem_addr); end
        compared++; if (fetch_count !== 16'(m_count)) begin mismatched++; $display("FAIL fault_count: got %0d want %0d", fetch_count, m_count); end
        for (int i = 0; i < 10; i++) begin
            tick(1'($urandom_range(0, 1)), 1'b0, 1'b0, 26'd0, 16'd0);
            compared++; if (imem_addr !== 32'h80 || fetch_fault !== 1'b1 || id_valid !== 1'b0) begin
                mismatched++; $display("FAIL halt%0d: got addr=%h fault=%0b valid=%0b want 80/1/0", i, imem_addr, fetch_fault, id_valid);
            end
        end
        do_reset();
        compared++; if (imem_addr !== 32'h0) begin mismatched++; $display("FAIL fault_reset_addr: got %h want 0", imem_addr); end
        compared++; if (fetch_fault !== 1'b0) begin mismatched++; $display("FAIL fault_reset_flag: got %0b want 0", fetch_fault); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b0, 26'd0, 16'd0);
        tick(1'b0, 1'b0, 1'b0, 26'd0, 16'd0);
        compared++; if (fetch_count !== 16'd3 || id_valid !== 1'b1) begin mismatched++; $display("FAIL pre_async: got count=%0d valid=%0b want 3/1", fetch_count, id_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        compared++; if (id_valid !== 1'b0 || id_inst !== 32'h0 || id_pc !== 32'h0) begin
            mismatched++; $display("FAIL async_ifid: got valid=%0b inst=%h pc=%h want 0/0/0", id_valid, id_inst, id_pc);
        end
        compared++; if (imem_addr !== 32'h0 || fetch_count !== 16'h0 || fetch_fault !== 1'b0) begin
            mismatched++; $display("FAIL async_state: got addr=%h count=%0d fault=%0b want 0/0/0", imem_addr, fetch_count, fetch_fault);
        end
        model_reset();
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_saturation();
        int exp_cnt;
        @(negedge clk);
        do_reset();
        for (int k = 1; k <= 25; k++) begin
            tick(1'b1, 1'b0, 1'b0, 26'd0, 16'd0);
            exp_cnt = (k - 1 < 15) ? k - 1 : 15;
            compared++; if (s_fetch_count !== 4'(exp_cnt)) begin mismatched++; $display("FAIL sat_count%0d: got %0d want %0d", k, s_fetch_count, exp_cnt); end
        end
    endtask

    task automatic test_random();
        int halt_cycles = 0;
        bit r, j, b;
        logic [25:0] ji;
        logic [15:0] bo;
        @(negedge clk);
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 3) != 0);
            j  = ($urandom_range(0, 9) == 0);
            b  = ($urandom_range(0, 6) == 0);
            ji = ($urandom_range(0, 19) == 0) ? 26'($urandom) : 26'($urandom_range(0, 31));
            bo = ($urandom_range(0, 19) == 0) ? 16'($urandom) : 16'($urandom_range(0, 16) - 8);
            tick(r, j, b, ji, bo);
            compared++; if (id_valid !== m_valid) begin mismatched++; $display("FAIL rnd%0d_valid: got %0b want %0b", i, id_valid, m_valid); end
            if (m_valid) begin
                compared++; if (id_pc !== m_pc) begin mismatched++; $display("FAIL rnd%0d_pc: got %h want %h", i, id_pc, m_pc); end
                compared++; if (id_inst !== mem[m_pc[6:2]]) begin mismatched++; $display("FAIL rnd%0d_inst: got %h want %h", i, id_inst, mem[m_pc[6:2]]); end
            end
            compared++; if (imem_addr !== m_next) begin mismatched++; $display("FAIL rnd%0d_addr: got %h want %h", i, imem_addr, m_next); end
            compared++; if (fetch_fault !== m_fault) begin mismatched++; $display("FAIL rnd%0d_fault: got %0b want %0b", i, fetch_fault, m_fault); end
            compared++; if (fetch_count !== 16'(m_count)) begin mismatched++; $display("FAIL rnd%0d_count: got %0d want %0d", i, fetch_count, m_count); end
            if (m_fault) halt_cycles++;
            if (halt_cycles >= 6) begin
                halt_cycles = 0;
                do_reset();
            end
        end
    endtask

    initial begin
        mem[0] = 32'h2001_0008;
        mem[1] = 32'h3402_000C;
        for (int i = 2; i < 32; i++) mem[i] = $urandom;
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_jump();
        test_fault();
        test_async_reset();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
